// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register: latches one decoded bundle per clock, with flush, freeze and bubble handling.
// Optional macro ID_STAGE_REG_FWD_EN adds the src1/src2 index registers used by the forwarding unit.
module id_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_operand_in,
    input  logic        imm_in,
    input  logic [23:0] signed_imm24_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  status_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] val_rn_out,
    output logic [31:0] val_rm_out,
    output logic [11:0] shift_operand_out,
    output logic        imm_out,
    output logic [23:0] signed_imm24_out,
    output logic [3:0]  exe_cmd_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic        wb_en_out,
    output logic        b_out,
    output logic        s_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  status_out,
    output logic [3:0]  src1_out,
    output logic [3:0]  src2_out
);

    // A flush wins over freeze; an invalid bundle on a load becomes a bubble.
    logic kill;
    assign kill = flush | (~freeze & ~valid_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out         <= 1'b0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            imm_out           <= 1'b0;
            signed_imm24_out  <= '0;
            exe_cmd_out       <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            dest_out          <= '0;
            status_out        <= '0;
        end else if (kill) begin
            valid_out         <= 1'b0;
            pc_out            <= '0;
            val_rn_out        <= '0;
            val_rm_out        <= '0;
            shift_operand_out <= '0;
            imm_out           <= 1'b0;
            signed_imm24_out  <= '0;
            exe_cmd_out       <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            b_out             <= 1'b0;
            s_out             <= 1'b0;
            dest_out          <= '0;
            status_out        <= '0;
        end else if (!freeze) begin
            valid_out         <= 1'b1;
            pc_out            <= pc_in;
            val_rn_out        <= val_rn_in;
            val_rm_out        <= val_rm_in;
            shift_operand_out <= shift_operand_in;
            imm_out           <= imm_in;
            signed_imm24_out  <= signed_imm24_in;
            exe_cmd_out       <= exe_cmd_in;
            mem_r_en_out      <= mem_r_en_in;
            mem_w_en_out      <= mem_w_en_in;
            wb_en_out         <= wb_en_in;
            b_out             <= b_in;
            s_out             <= s_in;
            dest_out          <= dest_in;
            status_out        <= status_in;
        end
    end

`ifdef ID_STAGE_REG_FWD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src1_out <= '0;
            src2_out <= '0;
        end else if (kill) begin
            src1_out <= '0;
            src2_out <= '0;
        end else if (!freeze) begin
            src1_out <= src1_in;
            src2_out <= src2_in;
        end
    end
`else
    // Without forwarding the indices are never consumed, so they are tied off.
    assign src1_out = 4'h0;
    assign src2_out = 4'h0;

    logic unused_src;
    assign unused_src = ^{src1_in, src2_in};
`endif

endmodule

// File: tb/tb_id_stage_reg.sv
// Self-checking bench for id_stage_reg: bundle-level reference model checked every cycle, plus directed literal checks.
module tb_id_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [11:0] shift;
        logic        imm;
        logic [23:0] simm;
        logic [3:0]  exe;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic [3:0]  dest;
        logic [3:0]  status;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    flush = 1'b0;
    logic    freeze = 1'b0;
    bundle_t in_b = '0;
    bundle_t out_b;
    bundle_t exp_b;

    int errors = 0;
    int checks = 0;

    logic        valid_out, imm_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm24_out;
    logic [3:0]  exe_cmd_out, dest_out, status_out, src1_out, src2_out;

    always #5 clk = ~clk;

    id_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .valid_in(in_b.valid), .pc_in(in_b.pc), .val_rn_in(in_b.rn), .val_rm_in(in_b.rm),
        .shift_operand_in(in_b.shift), .imm_in(in_b.imm), .signed_imm24_in(in_b.simm),
        .exe_cmd_in(in_b.exe), .mem_r_en_in(in_b.mr), .mem_w_en_in(in_b.mw), .wb_en_in(in_b.wb),
        .b_in(in_b.b), .s_in(in_b.s), .dest_in(in_b.dest), .status_in(in_b.status),
        .src1_in(in_b.src1), .src2_in(in_b.src2),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .shift_operand_out(shift_operand_out), .imm_out(imm_out), .signed_imm24_out(signed_imm24_out),
        .exe_cmd_out(exe_cmd_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .dest_out(dest_out),
        .status_out(status_out), .src1_out(src1_out), .src2_out(src2_out)
    );

    always_comb begin
        out_b = {valid_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out,
                 signed_imm24_out, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out,
                 b_out, s_out, dest_out, status_out, src1_out, src2_out};
    end

`ifdef ID_STAGE_REG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // What the stage should hold after a clean load of bundle x.
    function automatic bundle_t loaded(input bundle_t x);
        bundle_t r;
        r = x;
        if (!FWD) begin
            r.src1 = 4'h0;
            r.src2 = 4'h0;
        end
        return r;
    endfunction

    // Reference: a squash or an invalid bundle yields an all-zero bubble, a stall keeps the old bundle.
    always @(posedge clk or negedge rst) begin
        if (!rst)                   exp_b <= '0;
        else if (flush)             exp_b <= '0;
        else if (freeze)            exp_b <= exp_b;
        else if (!in_b.valid)       exp_b <= '0;
        else                        exp_b <= loaded(in_b);
    end

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model", out_b, exp_b);
        chk("invariant", valid_out ? 5'd0 : {mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out}, 5'd0);
    end

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bundle_t b, input logic fl, input logic fr);
        @(negedge clk);
        in_b   = b;
        flush  = fl;
        freeze = fr;
    endtask

    bundle_t b0;

    initial begin
        #3;
        chk("reset_zero", out_b, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic load
        b0 = '0;
        b0.valid = 1'b1; b0.pc = 32'h8; b0.exe = 4'h4; b0.wb = 1'b1; b0.dest = 4'h3; b0.src1 = 4'hA;
        drive(b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("load_pc", pc_out, 32'h8);
        chk("load_exe", exe_cmd_out, 4'h4);
        chk("load_wb", wb_en_out, 1'b1);
        chk("load_dest", dest_out, 4'h3);
        chk("load_valid", valid_out, 1'b1);
        chk("fwd_src1", src1_out, FWD ? 4'hA : 4'h0);

        // Freeze for three cycles while the next bundle waits
        b0.pc = 32'hC;
        drive(b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            edge_then_sample();
            chk("freeze_hold_pc", pc_out, 32'h8);
        end
        drive(b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("freeze_release_pc", pc_out, 32'hC);

        // Flush a store
        b0.mw = 1'b1; b0.pc = 32'h10;
        drive(b0, 1'b1, 1'b0);
        edge_then_sample();
        chk("flush_valid", valid_out, 1'b0);
        chk("flush_mw", mem_w_en_out, 1'b0);
        chk("flush_pc", pc_out, 32'h0);

        // Flush and freeze together still inserts a bubble
        b0.mw = 1'b0; b0.pc = 32'h14;
        drive(b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("reload_pc", pc_out, 32'h14);
        drive(b0, 1'b1, 1'b1);
        edge_then_sample();
        chk("flush_freeze_valid", valid_out, 1'b0);
        chk("flush_freeze_pc", pc_out, 32'h0);

        // Invalid bundle on a load is a bubble
        b0.valid = 1'b0; b0.wb = 1'b1; b0.pc = 32'h18;
        drive(b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("bubble_wb", wb_en_out, 1'b0);
        chk("bubble_pc", pc_out, 32'h0);

        // Async reset in the middle of a cycle
        b0.valid = 1'b1; b0.pc = 32'h20;
        drive(b0, 1'b0, 1'b0);
        edge_then_sample();
        chk("pre_reset_wb", wb_en_out, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("async_reset", out_b, '0);
        b0.pc = 32'h24;
        drive(b0, 1'b0, 1'b0);
        rst = 1'b1;
        edge_then_sample();
        chk("post_reset_pc", pc_out, 32'h24);
        chk("post_reset_valid", valid_out, 1'b1);

        // Back-to-back loads, one bundle per cycle
        for (int i = 0; i < 4; i++) begin
            b0.pc = 32'h100 + 32'(i * 4);
            drive(b0, 1'b0, 1'b0);
            edge_then_sample();
            chk("b2b_pc", pc_out, 32'h100 + 32'(i * 4));
        end

        // Mixed traffic checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            bundle_t r;
            r = bundle_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            drive(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end
        drive('0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
